// File: rtl/byte_stack_unstack.sv
// Width-conversion pair for the AES datapath: the stacker packs NWORDS narrow words into one
// wide block and the unstacker splits a wide block back into narrow words, first word in the MSBs.
module byte_stack_unstack #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     enable_i,
  input  logic                     stk_valid_i,
  output logic                     stk_ready_o,
  input  logic [WORD_W-1:0]        stk_word_i,
  output logic                     stk_valid_o,
  input  logic                     stk_ready_i,
  output logic [WORD_W*NWORDS-1:0] stk_word_o,
  input  logic                     ust_valid_i,
  output logic                     ust_ready_o,
  input  logic [WORD_W*NWORDS-1:0] ust_word_i,
  output logic                     ust_valid_o,
  input  logic                     ust_ready_i,
  output logic [WORD_W-1:0]        ust_word_o
);

  localparam int WIDE_W = WORD_W * NWORDS;
  localparam int IW     = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  // Handshake outputs are forced low while held in reset/clear or disabled.
  logic active;
  assign active = rst_ni & ~clr_i & enable_i;

  logic [IW-1:0]     count;
  logic [WORD_W-1:0] slot [NWORDS-1];
  logic [WIDE_W-1:0] block_out;
  logic [WIDE_W-1:0] block_next;
  logic              full;
  logic              stk_accept;
  logic              stk_complete;
  logic              stk_take;

  assign stk_valid_o  = active & full;
  assign stk_ready_o  = active & ~((count == LAST) & full & ~stk_ready_i);
  assign stk_word_o   = block_out;
  assign stk_accept   = stk_valid_i & stk_ready_o;
  assign stk_complete = stk_accept & (count == LAST);
  assign stk_take     = stk_valid_o & stk_ready_i;

  always_comb begin
    block_next = '0;
    for (int i = 0; i < NWORDS - 1; i++) begin
      block_next[(NWORDS-1-i)*WORD_W +: WORD_W] = slot[i];
    end
    block_next[WORD_W-1:0] = stk_word_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      count     <= '0;
      full      <= 1'b0;
      block_out <= '0;
      for (int i = 0; i < NWORDS - 1; i++) slot[i] <= '0;
    end else if (enable_i) begin
      if (stk_take) full <= 1'b0;
      // A completing word overrides the take so a fresh block stays presented.
      if (stk_complete) begin
        block_out <= block_next;
        full      <= 1'b1;
        count     <= '0;
      end else if (stk_accept) begin
        for (int i = 0; i < NWORDS - 1; i++) begin
          if (count == IW'(i)) slot[i] <= stk_word_i;
        end
        count <= count + IW'(1);
      end
    end
  end

  logic [WIDE_W-1:0] hold;
  logic              loaded;
  logic [IW-1:0]     index;
  logic              ust_emit;
  logic              ust_load;

  assign ust_valid_o = active & loaded;
  assign ust_ready_o = active & (~loaded | ((index == LAST) & ust_ready_i));
  assign ust_emit    = ust_valid_o & ust_ready_i;
  assign ust_load    = ust_valid_i & ust_ready_o;

  always_comb begin
    ust_word_o = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (index == IW'(i)) ust_word_o = hold[(NWORDS-1-i)*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      hold   <= '0;
      loaded <= 1'b0;
      index  <= '0;
    end else if (enable_i) begin
      if (ust_emit) begin
        if (index == LAST) begin
          loaded <= 1'b0;
          index  <= '0;
        end else begin
          index <= index + IW'(1);
        end
      end
      // Loading on the last emitted word gives back-to-back blocks without a bubble.
      if (ust_load) begin
        hold   <= ust_word_i;
        loaded <= 1'b1;
        index  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_byte_stack_unstack.sv
// Loopback bench: stacker wide output feeds the unstacker; a queue-based reference model
// predicts every wide block and every narrow word, and a monitor compares them on transfer.
module tb_byte_stack_unstack;

  logic         clk = 1'b0;
  logic         rst_n, clr, enable;
  logic         stk_in_vld, stk_in_rdy;
  logic [31:0]  stk_in_word;
  logic         stk_out_vld;
  logic [127:0] stk_out_word;
  logic         ust_in_rdy;
  logic         ust_out_vld, ust_out_rdy;
  logic [31:0]  ust_out_word;

  always #5 clk = ~clk;

  byte_stack_unstack #(.WORD_W(32), .NWORDS(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .enable_i    (enable),
    .stk_valid_i (stk_in_vld),
    .stk_ready_o (stk_in_rdy),
    .stk_word_i  (stk_in_word),
    .stk_valid_o (stk_out_vld),
    .stk_ready_i (ust_in_rdy),
    .stk_word_o  (stk_out_word),
    .ust_valid_i (stk_out_vld),
    .ust_ready_o (ust_in_rdy),
    .ust_word_i  (stk_out_word),
    .ust_valid_o (ust_out_vld),
    .ust_ready_i (ust_out_rdy),
    .ust_word_o  (ust_out_word)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            ust_mode = 1;  // 0: hold ready low, 1: high, 2: random
  logic [31:0]   pend[$];
  logic [127:0]  exp_stk[$];
  logic [31:0]   exp_ust[$];
  int            xfer_cyc[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: every four accepted words form one block, first word most significant.
  task automatic model_accept(input logic [31:0] w);
    pend.push_back(w);
    if (pend.size() == 4) begin
      exp_stk.push_back({pend[0], pend[1], pend[2], pend[3]});
      for (int i = 0; i < 4; i++) exp_ust.push_back(pend[i]);
      pend.delete();
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit got = 0;
    stk_in_vld  = 1'b1;
    stk_in_word = w;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (stk_in_rdy) begin
        model_accept(w);
        got = 1;
      end
      step();
    end
    stk_in_vld = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (exp_stk.size() != 0 || exp_ust.size() != 0); k++) @(negedge clk);
    check("drain_pending", exp_stk.size() + exp_ust.size(), 0);
    step();
  endtask

  initial begin
    rst_n       = 1'b0;
    clr         = 1'b0;
    enable      = 1'b1;
    stk_in_vld  = 1'b0;
    stk_in_word = '0;
    ust_out_rdy = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        case (ust_mode)
          0:       ust_out_rdy = 1'b0;
          1:       ust_out_rdy = 1'b1;
          default: ust_out_rdy = 1'($urandom_range(0, 1));
        endcase
      end
      forever begin
        @(negedge clk);
        cyc++;
        if (stk_out_vld && ust_in_rdy) begin
          if (exp_stk.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stk_unexpected: got %h expected none", stk_out_word);
          end else check("stk_block", stk_out_word, exp_stk.pop_front());
        end
        if (ust_out_vld && ust_out_rdy) begin
          xfer_cyc.push_back(cyc);
          if (exp_ust.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ust_unexpected: got %h expected none", ust_out_word);
          end else check("ust_word", ust_out_word, exp_ust.pop_front());
        end
      end
    join_none

    // Reset behaviour
    repeat (2) step();
    check("rst_stk_vld", stk_out_vld, 0);
    check("rst_ust_vld", ust_out_vld, 0);
    check("rst_stk_rdy", stk_in_rdy, 0);
    check("rst_ust_rdy", ust_in_rdy, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_stk_rdy", stk_in_rdy, 1);
    check("post_rst_ust_rdy", ust_in_rdy, 1);
    check("post_rst_stk_vld", stk_out_vld, 0);
    check("post_rst_ust_vld", ust_out_vld, 0);
    check("post_rst_stk_word", stk_out_word, 0);
    check("post_rst_ust_word", ust_out_word, 0);

    // Directed block with idle gaps; words must emerge on consecutive cycles
    xfer_cyc.delete();
    send_word(32'hAAAAAAAA); repeat (2) step();
    send_word(32'hBBBBBBBB); repeat (2) step();
    send_word(32'h12345678); repeat (2) step();
    send_word(32'h55555555);
    check("stk_latency_vld", stk_out_vld, 1);
    check("stk_latency_word", stk_out_word, 128'hAAAAAAAA_BBBBBBBB_12345678_55555555);
    drain();
    check("ust_burst_len", xfer_cyc.size(), 4);
    if (xfer_cyc.size() == 4) check("ust_burst_span", xfer_cyc[3] - xfer_cyc[0], 3);

    // Downstream stalled: two blocks buffered, third stalls only on its completing word
    ust_mode = 0;
    step();
    send_word(32'hBAAAAAAA); send_word(32'hFFFFFFFF);
    send_word(32'hABAAAAAA); send_word(32'h00000000);
    for (int i = 0; i < 4; i++) send_word($urandom);
    for (int i = 0; i < 3; i++) send_word($urandom);
    repeat (3) step();
    check("stall_no_output", exp_ust.size(), 8);
    check("stall_completing_word", stk_in_rdy, 0);
    ust_mode = 1;
    send_word($urandom);
    drain();

    // Back-to-back blocks: eight words on eight consecutive cycles
    xfer_cyc.delete();
    for (int i = 0; i < 8; i++) send_word($urandom);
    drain();
    check("b2b_len", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) check("b2b_span", xfer_cyc[7] - xfer_cyc[0], 7);

    // Clear drops a partial block
    send_word(32'hDEAD0001);
    send_word(32'hDEAD0002);
    clr = 1'b1;
    step();
    clr = 1'b0;
    pend.delete();
    check("clr_stk_vld", stk_out_vld, 0);
    check("clr_ust_vld", ust_out_vld, 0);
    send_word(32'h11111111); send_word(32'h22222222);
    send_word(32'h33333333); send_word(32'h44444444);
    drain();

    // Disable mid-block freezes the stacker
    send_word(32'hC0DE0001);
    send_word(32'hC0DE0002);
    enable      = 1'b0;
    stk_in_vld  = 1'b1;
    stk_in_word = 32'hC0DE0003;
    for (int i = 0; i < 3; i++) begin
      step();
      check("dis_stk_rdy", stk_in_rdy, 0);
      check("dis_ust_rdy", ust_in_rdy, 0);
    end
    enable = 1'b1;
    send_word(32'hC0DE0003);
    send_word(32'hC0DE0004);
    drain();

    // Randomized traffic with random downstream ready
    ust_mode = 2;
    for (int i = 0; i < 48; i++) begin
      send_word($urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    ust_mode = 1;
    drain();
    check("end_pending_partial", pend.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
